// File: rtl/des_round_ctrl.sv
// DES round controller: sequences key-schedule shifts and round enables
// through IDLE/LOAD/ROUND/FINAL/DONE with a Start/Busy/Done handshake.
module des_round_ctrl #(
  parameter int NUM_ROUNDS = 16,
  parameter int CNT_W = 5,
  parameter logic [NUM_ROUNDS-1:0] SHIFT_SCHED = 16'h7EFC
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Mode,
  input  logic             Stall,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] Round,
  output logic             Select_mux_pc,
  output logic [1:0]       Select_mux_shift,
  output logic             Shift_dir,
  output logic             Round_en,
  output logic             Final_en
);

  typedef enum logic [2:0] {
    IDLE, LOAD, ROUND, FINAL, DONE
  } state_t;

  localparam int SX_W = 2**CNT_W;
  localparam logic [SX_W-1:0] SCHED_X = SX_W'(SHIFT_SCHED);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_ROUNDS);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic mode_q, mode_nx;
  logic [CNT_W-1:0] idx;
  logic two;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      mode_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      mode_q <= mode_nx;
    end
  end

  // Decrypt walks the schedule backwards, offset by one round.
  assign idx = mode_q ? (LAST - cnt + ONE) : (cnt - ONE);
  assign two = SCHED_X[idx];

  always_comb begin
    state_nx         = state;
    cnt_nx           = cnt;
    mode_nx          = mode_q;
    Busy             = 1'b0;
    Done             = 1'b0;
    Round            = '0;
    Select_mux_pc    = 1'b0;
    Select_mux_shift = 2'b00;
    Shift_dir        = 1'b0;
    Round_en         = 1'b0;
    Final_en         = 1'b0;
    unique case (state)
      IDLE: begin
        if (Start) begin
          state_nx = LOAD;
          mode_nx  = Mode;
        end
      end
      LOAD: begin
        Busy          = 1'b1;
        Shift_dir     = mode_q;
        Select_mux_pc = 1'b1;
        state_nx      = ROUND;
        cnt_nx        = ONE;
      end
      ROUND: begin
        Busy      = 1'b1;
        Shift_dir = mode_q;
        Round     = cnt;
        // Stall gates this cycle's enables directly so no round is skipped.
        if (!Stall) begin
          Round_en = 1'b1;
          if (mode_q && cnt == ONE)
            Select_mux_shift = 2'b00;
          else if (two)
            Select_mux_shift = 2'b10;
          else
            Select_mux_shift = 2'b01;
          if (cnt == LAST) begin
            state_nx = FINAL;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + ONE;
          end
        end
      end
      FINAL: begin
        Busy      = 1'b1;
        Shift_dir = mode_q;
        Final_en  = 1'b1;
        state_nx  = DONE;
      end
      DONE: begin
        Busy      = 1'b1;
        Shift_dir = mode_q;
        Done      = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
